// File: rtl/hold_prompt_screen.sv
// Animated "press and hold" tutorial screen for the 96x64 RGB565 OLED.
// Blinking button sprite, pressed offset, hold progress bar and a one-shot done pulse.
module hold_prompt_screen #(
    parameter int          HOLD_FRAMES  = 60,
    parameter int          BLINK_FRAMES = 15,
    parameter int          BTN_X        = 44,
    parameter int          BTN_Y        = 53,
    parameter int          BAR_X        = 8,
    parameter int          BAR_Y        = 40,
    parameter int          BAR_W        = 40,
    parameter logic [15:0] BG           = 16'hFFFF,
    parameter logic [15:0] FG           = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_begin,
    input  logic        btn_held,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    output logic [15:0] oled_data,
    output logic        done,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PROMPT  = 2'd1,
        HOLDING = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [15:0] BLUE  = 16'h001F;
    localparam logic [15:0] LBLUE = 16'h5FFF;
    localparam logic [15:0] GREEN = 16'h07E0;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] HOLD_FULL  = 8'(HOLD_FRAMES);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    localparam logic [6:0] BAR_X0 = 7'(BAR_X);
    localparam logic [6:0] BAR_X1 = 7'(BAR_X + BAR_W - 1);
    localparam logic [5:0] BAR_Y0 = 6'(BAR_Y);
    localparam logic [5:0] BAR_Y1 = 6'(BAR_Y + 3);
    localparam logic [6:0] BTN_X0 = 7'(BTN_X);
    localparam logic [6:0] BTN_X1 = 7'(BTN_X + 14);
    localparam logic [5:0] BTN_Y0 = 6'(BTN_Y);
    localparam logic [6:0] X_LIM  = 7'd96;

    state_e      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;
    logic        done_q, done_d;
    logic [15:0] oled_q, oled_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_cnt_q  <= 8'd0;
            blink_cnt_q <= 8'd0;
            blink_q     <= 1'b0;
            done_q      <= 1'b0;
            oled_q      <= BG;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            done_q      <= done_d;
            oled_q      <= oled_d;
        end
    end

    // State only advances on frame_begin so a whole frame renders from one state.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (!enable) begin
            state_d     = IDLE;
            hold_cnt_d  = 8'd0;
            blink_cnt_d = 8'd0;
            blink_d     = 1'b0;
        end else if (frame_begin) begin
            unique case (state_q)
                IDLE: begin
                    state_d     = PROMPT;
                    hold_cnt_d  = 8'd0;
                    blink_cnt_d = 8'd0;
                    blink_d     = 1'b0;
                end
                PROMPT: begin
                    if (btn_held) begin
                        state_d    = HOLDING;
                        hold_cnt_d = 8'd1;
                    end else if (blink_cnt_q >= BLINK_LAST) begin
                        blink_cnt_d = 8'd0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 8'd1;
                    end
                end
                HOLDING: begin
                    if (!btn_held) begin
                        state_d     = PROMPT;
                        hold_cnt_d  = 8'd0;
                        blink_cnt_d = 8'd0;
                        blink_d     = 1'b0;
                    end else if (hold_cnt_q >= HOLD_LAST) begin
                        state_d    = DONE;
                        hold_cnt_d = HOLD_FULL;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    logic        in_bar, bar_edge, bar_fill;
    logic        in_btn, btn_edge;
    logic [5:0]  btn_y0, btn_y1;
    logic [15:0] bar_lhs, bar_rhs;
    logic [15:0] btn_fill;

    always_comb begin
        in_bar   = (x >= BAR_X0) && (x <= BAR_X1)
                && (y >= BAR_Y0) && (y <= BAR_Y1);
        bar_edge = in_bar && ((x == BAR_X0) || (x == BAR_X1)
                || (y == BAR_Y0) || (y == BAR_Y1));
        // Cross-multiplied fill test avoids a divider.
        bar_lhs  = (16'(x) - 16'(BAR_X + 1)) * 16'(HOLD_FRAMES);
        bar_rhs  = 16'(hold_cnt_q) * 16'(BAR_W - 2);
        bar_fill = bar_lhs < bar_rhs;

        btn_y0   = (state_q == HOLDING) ? (BTN_Y0 + 6'd1) : BTN_Y0;
        btn_y1   = btn_y0 + 6'd8;
        in_btn   = (x >= BTN_X0) && (x <= BTN_X1)
                && (y >= btn_y0) && (y <= btn_y1);
        btn_edge = (x == BTN_X0) || (x == BTN_X1)
                || (y == btn_y0) || (y == btn_y1);

        btn_fill = BLUE;
        if (state_q == DONE)
            btn_fill = GREEN;
        else if (state_q == PROMPT && blink_q)
            btn_fill = LBLUE;

        oled_d = BG;
        if (state_q == IDLE || x >= X_LIM)
            oled_d = BG;
        else if (bar_edge)
            oled_d = FG;
        else if (in_bar)
            oled_d = bar_fill ? GREEN : BG;
        else if (in_btn)
            oled_d = btn_edge ? FG : btn_fill;
    end

    assign oled_data = oled_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hold_prompt_screen.sv
// Directed bench for hold_prompt_screen: reset, blink, hold, release,
// pressed offset, completion pulse and abort paths.
module tb_hold_prompt_screen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        frame_begin;
    logic        btn_held;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] oled_data;
    logic        done;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    hold_prompt_screen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_begin (frame_begin),
        .btn_held    (btn_held),
        .x           (x),
        .y           (y),
        .oled_data   (oled_data),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic frame();
        frame_begin = 1'b1;
        @(posedge clk);
        #1;
        frame_begin = 1'b0;
    endtask

    task automatic get_pix(input logic [6:0] px, input logic [5:0] py,
                           output logic [15:0] p);
        x = px;
        y = py;
        @(posedge clk);
        #1;
        p = oled_data;
    endtask

    task automatic test_reset();
        logic [15:0] p;
        rst_n = 1'b0;
        enable = 1'b1;
        frame_begin = 1'b0;
        btn_held = 1'b0;
        x = 7'd50;
        y = 6'd57;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=0", state);
        end
        checks++;
        if (oled_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_oled got=%h exp=ffff", oled_data);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        rst_n = 1'b1;
        get_pix(7'd8, 6'd40, p);
        checks++;
        if (p !== 16'hFFFF) begin
            errors++;
            $display("FAIL idle_bg got=%h exp=ffff", p);
        end
    endtask

    task automatic test_blink();
        logic [15:0] p;
        logic [15:0] exp;
        frame();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL prompt_entry got=%0d exp=1", state);
        end
        get_pix(7'd50, 6'd57, p);
        checks++;
        if (p !== 16'h001F) begin
            errors++;
            $display("FAIL blink_f1 got=%h exp=001f", p);
        end
        for (int f = 2; f <= 31; f++) begin
            frame();
            exp = (f >= 16 && f <= 30) ? 16'h5FFF : 16'h001F;
            get_pix(7'd50, 6'd57, p);
            checks++;
            if (p !== exp) begin
                errors++;
                $display("FAIL blink_f%0d got=%h exp=%h", f, p, exp);
            end
        end
        get_pix(7'd50, 6'd53, p);
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("FAIL prompt_btn_top got=%h exp=0000", p);
        end
        get_pix(7'd8, 6'd41, p);
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("FAIL bar_outline got=%h exp=0000", p);
        end
        get_pix(7'd9, 6'd41, p);
        checks++;
        if (p !== 16'hFFFF) begin
            errors++;
            $display("FAIL prompt_bar_empty got=%h exp=ffff", p);
        end
    endtask

    task automatic test_early_release();
        logic [15:0] p;
        btn_held = 1'b1;
        frame();
        get_pix(7'd9, 6'd41, p);
        checks++;
        if (p !== 16'h07E0) begin
            errors++;
            $display("FAIL hold1_px9 got=%h exp=07e0", p);
        end
        get_pix(7'd10, 6'd41, p);
        checks++;
        if (p !== 16'hFFFF) begin
            errors++;
            $display("FAIL hold1_px10 got=%h exp=ffff", p);
        end
        for (int f = 2; f <= 30; f++) frame();
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL hold30_state got=%0d exp=2", state);
        end
        get_pix(7'd27, 6'd41, p);
        checks++;
        if (p !== 16'h07E0) begin
            errors++;
            $display("FAIL hold30_px27 got=%h exp=07e0", p);
        end
        get_pix(7'd28, 6'd42, p);
        checks++;
        if (p !== 16'hFFFF) begin
            errors++;
            $display("FAIL hold30_px28 got=%h exp=ffff", p);
        end
        get_pix(7'd50, 6'd53, p);
        checks++;
        if (p !== 16'hFFFF) begin
            errors++;
            $display("FAIL pressed_row53 got=%h exp=ffff", p);
        end
        get_pix(7'd50, 6'd54, p);
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("FAIL pressed_row54 got=%h exp=0000", p);
        end
        get_pix(7'd50, 6'd62, p);
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("FAIL pressed_row62 got=%h exp=0000", p);
        end
        get_pix(7'd50, 6'd57, p);
        checks++;
        if (p !== 16'h001F) begin
            errors++;
            $display("FAIL pressed_fill got=%h exp=001f", p);
        end
        get_pix(7'd100, 6'd41, p);
        checks++;
        if (p !== 16'hFFFF) begin
            errors++;
            $display("FAIL x_out_of_range got=%h exp=ffff", p);
        end
        btn_held = 1'b0;
        frame();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL release_state got=%0d exp=1", state);
        end
        get_pix(7'd9, 6'd41, p);
        checks++;
        if (p !== 16'hFFFF) begin
            errors++;
            $display("FAIL release_bar got=%h exp=ffff", p);
        end
        get_pix(7'd50, 6'd57, p);
        checks++;
        if (p !== 16'h001F) begin
            errors++;
            $display("FAIL release_blink got=%h exp=001f", p);
        end
    endtask

    task automatic test_complete_hold();
        logic [15:0] p;
        int pulses;
        btn_held = 1'b1;
        for (int f = 1; f <= 59; f++) frame();
        checks++;
        if (state !== 2'd2 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold59 got=%0d/%b exp=2/0", state, done);
        end
        frame();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL hold60_state got=%0d exp=3", state);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse got=%b exp=1", done);
        end
        pulses = 0;
        btn_held = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) frame_begin = 1'b1;
            @(posedge clk);
            #1;
            frame_begin = 1'b0;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL done_width extra=%0d exp=0", pulses);
        end
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL done_holds got=%0d exp=3", state);
        end
        get_pix(7'd9, 6'd41, p);
        checks++;
        if (p !== 16'h07E0) begin
            errors++;
            $display("FAIL full_px9 got=%h exp=07e0", p);
        end
        get_pix(7'd46, 6'd42, p);
        checks++;
        if (p !== 16'h07E0) begin
            errors++;
            $display("FAIL full_px46 got=%h exp=07e0", p);
        end
        get_pix(7'd47, 6'd41, p);
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("FAIL full_px47 got=%h exp=0000", p);
        end
        get_pix(7'd50, 6'd57, p);
        checks++;
        if (p !== 16'h07E0) begin
            errors++;
            $display("FAIL done_btn got=%h exp=07e0", p);
        end
        get_pix(7'd50, 6'd53, p);
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("FAIL done_btn_top got=%h exp=0000", p);
        end
    endtask

    task automatic test_abort_reset();
        logic [15:0] p;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (state !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort got=%0d/%b exp=0/0", state, done);
        end
        frame();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL rst_reenable got=%0d exp=1", state);
        end
        get_pix(7'd9, 6'd41, p);
        checks++;
        if (p !== 16'hFFFF) begin
            errors++;
            $display("FAIL rst_hold_clear got=%h exp=ffff", p);
        end
    endtask

    task automatic test_abort_enable();
        logic [15:0] p;
        btn_held = 1'b1;
        for (int f = 0; f < 10; f++) frame();
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (state !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL en_abort got=%0d/%b exp=0/0", state, done);
        end
        enable = 1'b1;
        btn_held = 1'b0;
        frame();
        get_pix(7'd9, 6'd41, p);
        checks++;
        if (p !== 16'hFFFF) begin
            errors++;
            $display("FAIL en_hold_clear got=%h exp=ffff", p);
        end
        btn_held = 1'b1;
        frame();
        get_pix(7'd10, 6'd41, p);
        checks++;
        if (state !== 2'd2 || p !== 16'hFFFF) begin
            errors++;
            $display("FAIL en_restart got=%0d/%h exp=2/ffff", state, p);
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_early_release();
        test_complete_hold();
        test_abort_reset();
        test_abort_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
